// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the execute-stage stall sequencer.
//   - fpucontrol opcode encodings
//   - aorf result-class encodings
//   - fpustall codes
//   - execute sequencer FSM state enum
package cpu_pkg;

  localparam logic [3:0] OP_FADD  = 4'b0000;
  localparam logic [3:0] OP_FSUB  = 4'b0001;
  localparam logic [3:0] OP_FMUL  = 4'b0010;
  localparam logic [3:0] OP_FDIV  = 4'b0011;
  localparam logic [3:0] OP_FSQRT = 4'b0100;
  localparam logic [3:0] OP_FTOI  = 4'b0101;
  localparam logic [3:0] OP_ITOF  = 4'b0110;
  localparam logic [3:0] OP_FNEG  = 4'b0111;
  localparam logic [3:0] OP_FMOV  = 4'b1000;

  localparam logic [1:0] AORF_ALU = 2'b00;
  localparam logic [1:0] AORF_FLT = 2'b01;
  localparam logic [1:0] AORF_INT = 2'b10;
  localparam logic [1:0] AORF_RSV = 2'b11;

  localparam logic [1:0] STALL_NONE = 2'b00;
  localparam logic [1:0] STALL_FPU  = 2'b01;
  localparam logic [1:0] STALL_RECV = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FPU_WAIT  = 2'd1,
    ST_RECV_WAIT = 2'd2
  } exec_state_e;

endpackage

// File: rtl/fpu_lat_lut.sv
// fpu_lat_lut: combinational FPU opcode -> latency (cycles) lookup.
//   op  : fpucontrol opcode
//   lat : latency in cycles; 0 means the op completes combinationally
module fpu_lat_lut
  import cpu_pkg::*;
#(
  parameter int unsigned LAT_FADD  = 2,
  parameter int unsigned LAT_FMUL  = 2,
  parameter int unsigned LAT_FDIV  = 5,
  parameter int unsigned LAT_FSQRT = 5,
  parameter int unsigned LAT_CVT   = 1,
  parameter int unsigned CNT_W     = 3
) (
  input  logic [3:0]       op,
  output logic [CNT_W-1:0] lat
);

  always_comb begin
    lat = '0;
    case (op)
      OP_FADD, OP_FSUB: lat = CNT_W'(LAT_FADD);
      OP_FMUL:          lat = CNT_W'(LAT_FMUL);
      OP_FDIV:          lat = CNT_W'(LAT_FDIV);
      OP_FSQRT:         lat = CNT_W'(LAT_FSQRT);
      OP_FTOI, OP_ITOF: lat = CNT_W'(LAT_CVT);
      default:          lat = '0;
    endcase
  end

endmodule

// File: rtl/exec_stall_ctrl.sv
// exec_stall_ctrl: execute-stage sequencer for the shared FPU and the
// receive port. Counts out multi-cycle FPU latency, waits for receive data,
// and drives the execute/upstream hold code.
//   clk, reset      : clock, async active-low reset
//   issue_valid     : first cycle of a new instruction in execute
//   aorf            : result class (ALU / FPU float / FPU int / reserved)
//   fpucontrol      : FPU opcode
//   readflag        : nonzero -> instruction consumes a receive word
//   recv_valid      : receive word available
//   flush           : kill the execute-stage instruction
//   fpustall        : 00 run, 01 FPU busy, 10 receive wait
//   stall_any       : OR of fpustall bits
//   recv_ack        : receive word consumed this cycle (pulse)
//   op_done         : final cycle of a multi-cycle FPU op (pulse)
//   busy_cnt        : remaining FPU cycles (debug)
module exec_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned LAT_FADD  = 2,
  parameter int unsigned LAT_FMUL  = 2,
  parameter int unsigned LAT_FDIV  = 5,
  parameter int unsigned LAT_FSQRT = 5,
  parameter int unsigned LAT_CVT   = 1,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [1:0]       aorf,
  input  logic [3:0]       fpucontrol,
  input  logic [1:0]       readflag,
  input  logic             recv_valid,
  input  logic             flush,
  output logic [1:0]       fpustall,
  output logic             stall_any,
  output logic             recv_ack,
  output logic             op_done,
  output logic [CNT_W-1:0] busy_cnt
);

  exec_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, lat;
  logic [1:0]       stall_c;
  logic             ack_c, done_c;
  logic             is_rd, is_fpu;

  fpu_lat_lut #(
    .LAT_FADD (LAT_FADD),
    .LAT_FMUL (LAT_FMUL),
    .LAT_FDIV (LAT_FDIV),
    .LAT_FSQRT(LAT_FSQRT),
    .LAT_CVT  (LAT_CVT),
    .CNT_W    (CNT_W)
  ) u_lat (
    .op (fpucontrol),
    .lat(lat)
  );

  // Receive has priority: a readflag op with an FPU class never starts a count.
  assign is_rd  = (readflag != 2'b00);
  assign is_fpu = (aorf == AORF_FLT) || (aorf == AORF_INT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    stall_c = STALL_NONE;
    ack_c   = 1'b0;
    done_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (issue_valid && !flush) begin
          if (is_rd) begin
            if (recv_valid) begin
              ack_c = 1'b1;
            end else begin
              stall_c = STALL_RECV;
              state_n = ST_RECV_WAIT;
            end
          end else if (is_fpu && lat > CNT_W'(1)) begin
            // Issue cycle counts toward latency, so L-1 cycles remain.
            stall_c = STALL_FPU;
            cnt_n   = lat - CNT_W'(1);
            state_n = ST_FPU_WAIT;
          end else if (is_fpu && lat == CNT_W'(1)) begin
            done_c = 1'b1;
          end
        end
      end
      ST_FPU_WAIT: begin
        cnt_n = (cnt != '0) ? cnt - CNT_W'(1) : '0;
        if (cnt > CNT_W'(1)) begin
          stall_c = STALL_FPU;
        end else begin
          // Last cycle: result is ready, release the hold.
          done_c  = (cnt == CNT_W'(1));
          state_n = ST_IDLE;
        end
      end
      ST_RECV_WAIT: begin
        if (recv_valid) begin
          ack_c   = 1'b1;
          state_n = ST_IDLE;
        end else begin
          stall_c = STALL_RECV;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
    if (flush) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      stall_c = STALL_NONE;
      ack_c   = 1'b0;
      done_c  = 1'b0;
    end
  end

  // Issue-cycle outputs are Mealy, so gate them while reset is asserted.
  assign fpustall  = reset ? stall_c : STALL_NONE;
  assign recv_ack  = reset & ack_c;
  assign op_done   = reset & done_c;
  assign stall_any = |fpustall;
  assign busy_cnt  = cnt;

endmodule

// File: tb/tb_exec_stall_ctrl.sv
// tb_exec_stall_ctrl: directed scenarios plus a randomized run against a
// timeline-based reference model (op completion cycle / pending receive).
module tb_exec_stall_ctrl;
  import cpu_pkg::*;

  localparam int LAT_FADD  = 2;
  localparam int LAT_FMUL  = 2;
  localparam int LAT_FDIV  = 5;
  localparam int LAT_FSQRT = 5;
  localparam int LAT_CVT   = 1;
  localparam int CNT_W     = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic [1:0]       aorf;
  logic [3:0]       fpucontrol;
  logic [1:0]       readflag;
  logic             recv_valid;
  logic             flush;
  logic [1:0]       fpustall;
  logic             stall_any;
  logic             recv_ack;
  logic             op_done;
  logic [CNT_W-1:0] busy_cnt;

  int n_cmp = 0;
  int n_err = 0;

  exec_stall_ctrl #(
    .LAT_FADD(LAT_FADD), .LAT_FMUL(LAT_FMUL), .LAT_FDIV(LAT_FDIV),
    .LAT_FSQRT(LAT_FSQRT), .LAT_CVT(LAT_CVT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .aorf(aorf),
    .fpucontrol(fpucontrol), .readflag(readflag), .recv_valid(recv_valid),
    .flush(flush), .fpustall(fpustall), .stall_any(stall_any),
    .recv_ack(recv_ack), .op_done(op_done), .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Packed view of outputs: {stall_any, fpustall, recv_ack, op_done, busy_cnt}
  function automatic logic [7:0] obs();
    return {stall_any, fpustall, recv_ack, op_done, busy_cnt};
  endfunction

  function automatic logic [7:0] e(input logic [1:0] s, input logic a, input logic d,
                                   input logic [2:0] b);
    return {(s != 2'b00), s, a, d, b};
  endfunction

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: return LAT_FADD;
      4'd2:       return LAT_FMUL;
      4'd3:       return LAT_FDIV;
      4'd4:       return LAT_FSQRT;
      4'd5, 4'd6: return LAT_CVT;
      default:    return 0;
    endcase
  endfunction

  task automatic drv(input logic iv, input logic [1:0] af, input logic [3:0] op,
                     input logic [1:0] rf, input logic rv, input logic fl);
    issue_valid = iv; aorf = af; fpucontrol = op; readflag = rf;
    recv_valid = rv; flush = fl;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drv(0, AORF_ALU, OP_FADD, 2'b00, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (obs() !== 8'h00) begin n_err++; $display("FAIL reset_outs got %b want %b", obs(), 8'h00); end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== 8'h00) begin n_err++; $display("FAIL reset_idle got %b want %b", obs(), 8'h00); end
    @(posedge clk); #1;
  endtask

  // issue_valid held through the wait to confirm it is ignored outside IDLE
  task automatic test_fdiv();
    logic [7:0] want [6];
    want = '{e(STALL_FPU,0,0,0), e(STALL_FPU,0,0,4), e(STALL_FPU,0,0,3),
             e(STALL_FPU,0,0,2), e(STALL_NONE,0,1,1), e(STALL_NONE,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      drv(i < 5, AORF_FLT, OP_FDIV, 2'b00, 0, 0);
      @(negedge clk);
      n_cmp++;
      if (obs() !== want[i]) begin n_err++; $display("FAIL fdiv c%0d got %b want %b", i, obs(), want[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [4];
    want = '{e(STALL_NONE,0,1,0), e(STALL_FPU,0,0,0), e(STALL_NONE,0,1,1), e(STALL_NONE,0,0,0)};
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: drv(1, AORF_INT, OP_FTOI, 2'b00, 0, 0);
        1: drv(1, AORF_FLT, OP_FADD, 2'b00, 0, 0);
        default: drv(0, AORF_ALU, OP_FADD, 2'b00, 0, 0);
      endcase
      @(negedge clk);
      n_cmp++;
      if (obs() !== want[i]) begin n_err++; $display("FAIL b2b c%0d got %b want %b", i, obs(), want[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_recv_wait();
    logic [7:0] want [6];
    want = '{e(STALL_RECV,0,0,0), e(STALL_RECV,0,0,0), e(STALL_RECV,0,0,0),
             e(STALL_NONE,1,0,0), e(STALL_NONE,0,0,0), e(STALL_NONE,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      drv(i == 0, AORF_ALU, OP_FADD, 2'b01, i >= 3, 0);
      @(negedge clk);
      n_cmp++;
      if (obs() !== want[i]) begin n_err++; $display("FAIL recv_wait c%0d got %b want %b", i, obs(), want[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_recv_bypass_fneg();
    logic [7:0] want [6];
    want = '{e(STALL_NONE,1,0,0), e(STALL_NONE,0,0,0), e(STALL_NONE,0,0,0),
             e(STALL_NONE,0,0,0), e(STALL_NONE,0,0,0), e(STALL_RECV,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: drv(1, AORF_FLT, OP_FDIV, 2'b10, 1, 0);  // receive beats FPU class
        1: drv(1, AORF_FLT, OP_FNEG, 2'b00, 1, 0);
        2: drv(1, AORF_FLT, OP_FMOV, 2'b00, 0, 0);
        3: drv(1, AORF_ALU, OP_FDIV, 2'b00, 0, 0);
        4: drv(1, AORF_RSV, OP_FSQRT, 2'b00, 0, 0);
        default: drv(1, AORF_INT, OP_FDIV, 2'b11, 0, 0);
      endcase
      @(negedge clk);
      n_cmp++;
      if (obs() !== want[i]) begin n_err++; $display("FAIL bypass c%0d got %b want %b", i, obs(), want[i]); end
      @(posedge clk); #1;
    end
    // leave RECV_WAIT via flush; no ack in the flushed cycle
    drv(0, AORF_ALU, OP_FADD, 2'b00, 1, 1);
    @(negedge clk);
    n_cmp++;
    if (obs() !== e(STALL_NONE,0,0,0)) begin n_err++; $display("FAIL recv_flush got %b want %b", obs(), e(STALL_NONE,0,0,0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [7:0] want [8];
    want = '{e(STALL_FPU,0,0,0), e(STALL_FPU,0,0,4), e(STALL_NONE,0,0,3), e(STALL_NONE,0,0,0),
             e(STALL_NONE,0,0,0), e(STALL_FPU,0,0,0), e(STALL_NONE,0,1,1), e(STALL_NONE,0,0,0)};
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1: drv(1, AORF_FLT, OP_FSQRT, 2'b00, 0, 0);
        2: drv(1, AORF_FLT, OP_FSQRT, 2'b00, 0, 1);
        5: drv(1, AORF_FLT, OP_FMUL, 2'b00, 0, 0);
        default: drv(0, AORF_ALU, OP_FADD, 2'b00, 0, 0);
      endcase
      @(negedge clk);
      n_cmp++;
      if (obs() !== want[i]) begin n_err++; $display("FAIL flush c%0d got %b want %b", i, obs(), want[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    drv(1, AORF_FLT, OP_FSQRT, 2'b00, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (obs() !== e(STALL_FPU,0,0,0)) begin n_err++; $display("FAIL arst_issue got %b want %b", obs(), e(STALL_FPU,0,0,0)); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    // mid-FPU_WAIT (counter 3), issue_valid still high: reset between edges
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 8'h00) begin n_err++; $display("FAIL arst_outs got %b want %b", obs(), 8'h00); end
    @(negedge clk);
    reset = 1'b1;
    drv(0, AORF_ALU, OP_FADD, 2'b00, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== 8'h00) begin n_err++; $display("FAIL arst_idle got %b want %b", obs(), 8'h00); end
    @(posedge clk); #1;
    drv(1, AORF_FLT, OP_FADD, 2'b00, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (obs() !== e(STALL_FPU,0,0,0)) begin n_err++; $display("FAIL arst_next0 got %b want %b", obs(), e(STALL_FPU,0,0,0)); end
    @(posedge clk); #1;
    drv(0, AORF_ALU, OP_FADD, 2'b00, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (obs() !== e(STALL_NONE,0,1,1)) begin n_err++; $display("FAIL arst_next1 got %b want %b", obs(), e(STALL_NONE,0,1,1)); end
    @(posedge clk); #1;
  endtask

  // Model: an FPU op issued at cycle t0 with latency L finishes at t0+L-1;
  // busy_cnt in a later cycle t is the cycles left including t.
  task automatic test_random();
    bit         m_fpu = 0, m_recv = 0;
    int         fpu_end = 0;
    logic       iv, rv, fl;
    logic [1:0] af, rf, s;
    logic [3:0] op;
    logic       a, d;
    int         b, L;
    for (int t = 0; t < 600; t++) begin
      iv = ($urandom_range(0, 1) == 1);
      af = 2'($urandom_range(0, 3));
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      rf = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      rv = ($urandom_range(0, 2) == 0);
      fl = ($urandom_range(0, 11) == 0);
      drv(iv, af, op, rf, rv, fl);
      s = STALL_NONE; a = 0; d = 0; b = 0;
      if (m_fpu) begin
        b = fpu_end - t + 1;
        if (t < fpu_end) s = STALL_FPU;
        else begin d = 1; m_fpu = 0; end
      end else if (m_recv) begin
        if (rv) begin a = 1; m_recv = 0; end
        else s = STALL_RECV;
      end else if (iv && !fl) begin
        if (rf != 2'b00) begin
          if (rv) a = 1;
          else begin s = STALL_RECV; m_recv = 1; end
        end else if (af == AORF_FLT || af == AORF_INT) begin
          L = lat_of(op);
          if (L >= 2) begin s = STALL_FPU; m_fpu = 1; fpu_end = t + L - 1; end
          else if (L == 1) d = 1;
        end
      end
      if (fl) begin s = STALL_NONE; a = 0; d = 0; m_fpu = 0; m_recv = 0; end
      @(negedge clk);
      n_cmp++;
      if (obs() !== e(s, a, d, 3'(b))) begin
        n_err++;
        $display("FAIL rand t%0d got %b want %b", t, obs(), e(s, a, d, 3'(b)));
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_fdiv();
    test_back_to_back();
    test_recv_wait();
    test_recv_bypass_fneg();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
